// File: rtl/re_result_deserializer_32.sv
`default_nettype none
// ============================================================================
//  Module   : re_result_deserializer_32
//  Purpose  : Gathers the serial per-element results of the recurrent linear
//             stage (one word per done pulse) into a parallel N_ELEM-word
//             vector tagged with its gate (z/r/h). A two-bank ping-pong buffer
//             lets the next frame fill while the previous one waits for the
//             gate activation / GRU combine consumer.
//  Ports    :
//    clk        in   clock
//    rst_n      in   synchronous active-low reset
//    in_valid   in   result word present (linear stage done)
//    in_data    in   result word (linear stage dout)
//    in_gate    in   gate tag, sampled on the element-0 beat (3 = reserved)
//    flush      in   discard the partially filled write bank
//    in_ready   out  write bank can accept a word
//    out_valid  out  read bank holds a complete frame
//    out_ready  in   consumer accepts the frame
//    out_vec    out  read-bank contents, element i at index i
//    out_gate   out  gate tag of the read bank
//    overflow   out  sticky: a word arrived while in_ready was low
//    bad_gate   out  sticky: reserved tag 3 sampled at element 0
//  Revision : 1.0  initial release
// ============================================================================
module re_result_deserializer_32 #(
  parameter int N_ELEM = 32,  // power of two, 1..32
  parameter int W      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_gate,
  input  logic         flush,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_vec [N_ELEM-1:0],
  output logic [1:0]   out_gate,
  output logic         overflow,
  output logic         bad_gate
);

  // Index width; a single-element frame still needs a 1-bit counter.
  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_ELEM - 1);
  localparam logic [IDX_W-1:0] c_idx_one  = IDX_W'(1);
  localparam logic [1:0]       c_gate_rsv = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [W-1:0]     r_mem [2][N_ELEM];
  logic [1:0]       r_full;
  logic [1:0]       r_gate [2];
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_overflow;
  logic             r_bad_gate;

  // --------------------------------------------------------------------------
  // Control decode (registered state plus this cycle's handshakes)
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_out_valid;
  logic w_wr_beat;
  logic w_wr_last;
  logic w_wr_first;
  logic w_drop;
  logic w_rd_fire;

  assign w_in_ready  = !r_full[r_wr_bank];
  assign w_out_valid = r_full[r_rd_bank];

  // flush wins over any word presented in the same cycle, and a word
  // discarded by flush is not an overflow.
  assign w_wr_beat  = in_valid && w_in_ready && !flush;
  assign w_drop     = in_valid && !w_in_ready && !flush;
  assign w_wr_first = (r_wr_idx == '0);
  assign w_wr_last  = (r_wr_idx == c_idx_last);
  assign w_rd_fire  = w_out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Frame storage. Cleared on reset so out_vec reads all-zero afterwards;
  // never cleared on consume, so out_vec is only meaningful with out_valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < N_ELEM; e++) begin
          r_mem[b][e] <= '0;
        end
      end
    end else if (w_wr_beat) begin
      r_mem[r_wr_bank][r_wr_idx] <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // Bank bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_gate[0]  <= '0;
      r_gate[1]  <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_idx   <= '0;
      r_overflow <= 1'b0;
      r_bad_gate <= 1'b0;
    end else begin
      // Write side
      if (flush) begin
        r_wr_idx <= '0;
      end else if (w_wr_beat) begin
        if (w_wr_first) begin
          r_gate[r_wr_bank] <= in_gate;
          if (in_gate == c_gate_rsv) begin
            r_bad_gate <= 1'b1;
          end
        end
        if (w_wr_last) begin
          r_full[r_wr_bank] <= 1'b1;
          r_wr_bank         <= ~r_wr_bank;
          r_wr_idx          <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + c_idx_one;
        end
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end

      // Read side. A fill only targets an empty bank and a consume only a
      // full one, so the two never touch the same full bit in one cycle.
      if (w_rd_fire) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all derived from registered state only
  // --------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_gate  = r_gate[r_rd_bank];
  assign overflow  = r_overflow;
  assign bad_gate  = r_bad_gate;

  for (genvar i = 0; i < N_ELEM; i++) begin : g_out_vec
    assign out_vec[i] = r_mem[r_rd_bank][i];
  end

endmodule
`default_nettype wire

// File: tb/tb_re_result_deserializer_32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_re_result_deserializer_32
//  Purpose  : Directed self-checking bench for re_result_deserializer_32.
//  Revision : 1.0  initial release
// ============================================================================
module tb_re_result_deserializer_32;

  localparam int N = 32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [1:0]  in_gate;
  logic        flush;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_vec [N-1:0];
  logic [1:0]  out_gate;
  logic        overflow;
  logic        bad_gate;

  int n_checks = 0;
  int n_errors = 0;

  re_result_deserializer_32 #(.N_ELEM(N), .W(32)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_gate   (in_gate),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_gate  (out_gate),
    .overflow  (overflow),
    .bad_gate  (bad_gate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] g);
    in_valid = 1'b1;
    in_data  = d;
    in_gate  = g;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [31:0] base, input logic [1:0] g);
    for (int i = 0; i < N; i++) beat(base + 32'(i), g);
  endtask

  task automatic check_reset_outputs(input string pfx);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc | out_vec[i];
    check({pfx, "_in_ready"},  32'(in_ready),  32'd1);
    check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    check({pfx, "_out_gate"},  32'(out_gate),  32'd0);
    check({pfx, "_overflow"},  32'(overflow),  32'd0);
    check({pfx, "_bad_gate"},  32'(bad_gate),  32'd0);
    check({pfx, "_vec_or"},    acc,            32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int bad_valid;
    int ready_low;
    int f;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_gate   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // ---------------- Reset and basic frame ----------------
    do_reset();
    check_reset_outputs("rst");

    frame(32'h100, 2'd0);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_gate",  32'(out_gate),  32'd0);
    check("basic_ready", 32'(in_ready),  32'd1);
    for (int i = 0; i < N; i++)
      check($sformatf("basic_vec%0d", i), out_vec[i], 32'h100 + 32'(i));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("basic_consumed", 32'(out_valid), 32'd0);

    // ---------------- Back-to-back z/r/h ----------------
    out_ready = 1'b1;
    pulses    = 0;
    bad_valid = 0;
    ready_low = 0;
    for (int g = 0; g < 3 * N; g++) begin
      f = g / N;
      if (!in_ready) ready_low++;
      beat(32'h2000 + 32'(f) * 32'h100 + 32'(g % N), 2'(f));
      if ((g % N) == N - 1) begin
        check($sformatf("b2b_valid%0d", f), 32'(out_valid), 32'd1);
        check($sformatf("b2b_gate%0d", f),  32'(out_gate),  32'(f));
        check($sformatf("b2b_f%0d_e0", f),  out_vec[0],  32'h2000 + 32'(f) * 32'h100);
        check($sformatf("b2b_f%0d_e17", f), out_vec[17], 32'h2011 + 32'(f) * 32'h100);
        check($sformatf("b2b_f%0d_e31", f), out_vec[31], 32'h201F + 32'(f) * 32'h100);
        pulses++;
      end else if (out_valid) begin
        bad_valid++;
      end
    end
    tick();
    out_ready = 1'b0;
    check("b2b_pulses",      32'(pulses),    32'd3);
    check("b2b_extra_valid", 32'(bad_valid), 32'd0);
    check("b2b_ready_low",   32'(ready_low), 32'd0);
    check("b2b_overflow",    32'(overflow),  32'd0);
    check("b2b_drained",     32'(out_valid), 32'd0);

    // ---------------- Backpressure / overflow ----------------
    frame(32'h3000, 2'd1);
    frame(32'h3100, 2'd2);
    check("bp_ready_low", 32'(in_ready),  32'd0);
    check("bp_valid",     32'(out_valid), 32'd1);
    check("bp_ovf_pre",   32'(overflow),  32'd0);
    beat(32'hDEAD, 2'd0);
    check("bp_overflow",  32'(overflow),  32'd1);
    check("bp_f1_gate",   32'(out_gate),  32'd1);
    check("bp_f1_e0",     out_vec[0],     32'h3000);
    check("bp_f1_e31",    out_vec[31],    32'h301F);
    out_ready = 1'b1;
    tick();
    check("bp_f2_valid",  32'(out_valid), 32'd1);
    check("bp_f2_gate",   32'(out_gate),  32'd2);
    check("bp_f2_e0",     out_vec[0],     32'h3100);
    check("bp_f2_e31",    out_vec[31],    32'h311F);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    check("bp_drained",   32'(out_valid), 32'd0);

    // ---------------- Flush ----------------
    do_reset();
    check("fl_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 10; i++) beat(32'h4000 + 32'(i), 2'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD;
    in_gate  = 2'd1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_no_valid", 32'(out_valid), 32'd0);
    check("fl_no_ovf",   32'(overflow),  32'd0);
    frame(32'h4100, 2'd2);
    check("fl_valid", 32'(out_valid), 32'd1);
    check("fl_gate",  32'(out_gate),  32'd2);
    check("fl_e0",    out_vec[0],     32'h4100);
    check("fl_e9",    out_vec[9],     32'h4109);
    check("fl_e10",   out_vec[10],    32'h410A);
    check("fl_e31",   out_vec[31],    32'h411F);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---------------- Simultaneous fill / consume ----------------
    frame(32'h5000, 2'd0);
    for (int i = 0; i < N - 1; i++) beat(32'h5100 + 32'(i), 2'd1);
    check("sim_a_valid", 32'(out_valid), 32'd1);
    check("sim_a_gate",  32'(out_gate),  32'd0);
    out_ready = 1'b1;
    beat(32'h511F, 2'd1);
    out_ready = 1'b0;
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_gate",  32'(out_gate),  32'd1);
    check("sim_e0",    out_vec[0],     32'h5100);
    check("sim_e31",   out_vec[31],    32'h511F);
    check("sim_ready", 32'(in_ready),  32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim_drained", 32'(out_valid), 32'd0);

    // ---------------- Reset mid-operation, bad gate ----------------
    frame(32'h6000, 2'd1);
    for (int i = 0; i < 5; i++) beat(32'h6100 + 32'(i), 2'd2);
    do_reset();
    check_reset_outputs("mid");
    frame(32'h7000, 2'd3);
    check("bg_flag",  32'(bad_gate),  32'd1);
    check("bg_valid", 32'(out_valid), 32'd1);
    check("bg_gate",  32'(out_gate),  32'd3);
    check("bg_e0",    out_vec[0],     32'h7000);
    check("bg_e5",    out_vec[5],     32'h7005);
    check("bg_e31",   out_vec[31],    32'h701F);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
